score_pulse_gen: RTL and testbench
==================================

Name: score_pulse_gen

Overview:
- Writer side of the score counter interface.
- Accepts brick-hit events, each carrying a point value and a player select, and queues them in a small FIFO.
- Replays each event as a train of evenly spaced COUNT_1 or COUNT_2 pulses, one pulse per point, to drive the BCD score counters.
- Sits between brick/collision logic and the score registers; the counters increment once per pulse edge.

Parameters:
- PULSE_HIGH, 4, cycles each COUNT pulse stays high (1..15)
- PULSE_GAP, 4, low cycles between consecutive pulses (1..15)
- FIFO_DEPTH, 4, hit-event queue entries (power of 2, 2..16)

Ports:
- CLK_DRV  in  1  system clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- START_GAME_N  in  1  active-low; while low, behaves as RESET and also clears OVERFLOW
- HIT  in  1  one-cycle strobe: hit event present
- HIT_POINTS  in  3  point value of the event, 0..7
- HIT_PLAYER2  in  1  sampled with HIT; 1 = player 2, 0 = player 1
- COUNT_1  out  1  registered pulse train to player 1 counters
- COUNT_2  out  1  registered pulse train to player 2 counters
- BUSY  out  1  high while FIFO is non-empty or a pulse train is in progress
- FULL  out  1  FIFO holds FIFO_DEPTH entries
- OVERFLOW  out  1  sticky; set when a HIT is dropped

Behaviour:
- Reset (RESET=1 or START_GAME_N=0 at an edge):
  - Next cycle: COUNT_1=0, COUNT_2=0, BUSY=0, FULL=0.
  - FIFO is emptied and the FSM goes to IDLE.
  - OVERFLOW is cleared by START_GAME_N=0 and by RESET.
  - Applies mid-train: a pulse in progress is truncated and never resumes.
- Enqueue:
  - Condition: HIT=1, HIT_POINTS!=0, FULL=0 in the current cycle.
  - Writes {HIT_POINTS, HIT_PLAYER2}.
  - HIT with HIT_POINTS=0 is ignored; it does not set OVERFLOW.
  - HIT with FULL=1 is dropped and sets OVERFLOW, even if a pop occurs the same cycle.
  - A push and a pop in the same cycle are both performed and the count is unchanged.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: if the FIFO is non-empty, pop the head into REM (3 bits) and PL (1 bit), load the timer with PULSE_HIGH-1, go to HIGH.
  - HIGH: COUNT_x=1, where x=2 if PL else 1. Decrement the timer; at 0, load PULSE_GAP-1, decrement REM, go to LOW.
  - LOW: both COUNT outputs are 0. Decrement the timer; at 0:
    - If REM!=0, load PULSE_HIGH-1 and go to HIGH.
    - Otherwise go to IDLE; IDLE may pop the next entry in that same cycle.
  - Back-to-back events: each boundary spaces pulses by PULSE_GAP low cycles plus 1 IDLE cycle.
- Timing:
  - COUNT outputs are registered and decoded from state; they are never high in IDLE or LOW.
  - COUNT_1 and COUNT_2 are never high together.
  - Latency: HIT at cycle t with FSM idle and FIFO empty gives first COUNT high at cycle t+2.
  - One event of N points occupies exactly N*(PULSE_HIGH+PULSE_GAP) cycles from its first high cycle.
- BUSY = (FIFO count != 0) | (state != IDLE).
- FIFO:
  - Circular buffer with wrap-around read/write pointers and a count of width clog2(FIFO_DEPTH)+1.
  - Head-first order is preserved across both players.

Test Plan:
- Single event: reset, then HIT=1, HIT_POINTS=3, HIT_PLAYER2=0 for 1 cycle → COUNT_1 high cycles t+2..t+5, t+10..t+13, t+18..t+21; COUNT_2 stays 0; BUSY falls at t+26.
- Player interleave: HIT (5, P1) then next cycle HIT (2, P2) → 5 COUNT_1 pulses, then 1 idle cycle, then 2 COUNT_2 pulses; no overlap.
- Overflow: with FIFO_DEPTH=4, issue 6 HITs of 7 points on consecutive cycles starting from idle → first entry popped at t+1, so HIT #6 is dropped and OVERFLOW=1; FULL=1 seen; exactly 5×7=35 pulses are emitted.
- Zero points: HIT with HIT_POINTS=0 → no pulses, BUSY stays 0, OVERFLOW stays 0.
- Reset mid-train: HIT (7, P2), assert RESET during the 3rd high phase → COUNT_2=0 the next cycle, BUSY=0, and no further pulses after RESET is released.
- Start game: set OVERFLOW, then hold START_GAME_N=0 for 1 cycle → OVERFLOW=0 and FIFO empty; a following HIT (1, P1) produces exactly 1 COUNT_1 pulse.

Source files
------------

// File: rtl/score_pulse_gen.sv
// score_pulse_gen: queues brick-hit events and replays each one as a train of
// evenly spaced COUNT_1/COUNT_2 pulses, one pulse per point, for the BCD score counters.
//
// state | meaning
// IDLE  | no train running; pops the FIFO head when one is waiting
// HIGH  | COUNT_x asserted for PULSE_HIGH cycles
// LOW   | both COUNT outputs low for PULSE_GAP cycles
module score_pulse_gen #(
  parameter int PULSE_HIGH = 4,
  parameter int PULSE_GAP  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLK_DRV,
  input  logic       RESET,
  input  logic       START_GAME_N,
  input  logic       HIT,
  input  logic [2:0] HIT_POINTS,
  input  logic       HIT_PLAYER2,
  output logic       COUNT_1,
  output logic       COUNT_2,
  output logic       BUSY,
  output logic       FULL,
  output logic       OVERFLOW
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0]    HIGH_LOAD = 4'(PULSE_HIGH - 1);
  localparam logic [3:0]    GAP_LOAD  = 4'(PULSE_GAP - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t        state_q;
  logic [3:0]    timer_q;
  logic [2:0]    rem_q;
  logic          pl_q;
  logic          count_1_q, count_2_q;

  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          overflow_q, overflow_d;

  logic          clr, hit_valid, full, push, pop;
  logic [3:0]    head;

  assign clr       = RESET | ~START_GAME_N;
  assign hit_valid = HIT & (HIT_POINTS != 3'd0);
  assign full      = (cnt_q == DEPTH_C);
  assign push      = hit_valid & ~full;
  assign pop       = (state_q == IDLE) & (cnt_q != '0);
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
    // A drop is judged on FULL alone, so a same-cycle pop does not rescue it.
    if (hit_valid && full) overflow_d = 1'b1;
  end

  always_ff @(posedge CLK_DRV) begin
    if (clr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge CLK_DRV) begin
    if (push) mem_q[wr_ptr_q] <= {HIT_POINTS, HIT_PLAYER2};
  end

  always_ff @(posedge CLK_DRV) begin
    if (clr) begin
      state_q   <= IDLE;
      timer_q   <= 4'd0;
      rem_q     <= 3'd0;
      pl_q      <= 1'b0;
      count_1_q <= 1'b0;
      count_2_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            rem_q     <= head[3:1];
            pl_q      <= head[0];
            timer_q   <= HIGH_LOAD;
            state_q   <= HIGH;
            count_1_q <= ~head[0];
            count_2_q <= head[0];
          end
        end
        HIGH: begin
          if (timer_q == 4'd0) begin
            timer_q   <= GAP_LOAD;
            rem_q     <= rem_q - 3'd1;
            state_q   <= LOW;
            count_1_q <= 1'b0;
            count_2_q <= 1'b0;
          end else begin
            timer_q <= timer_q - 4'd1;
          end
        end
        LOW: begin
          if (timer_q == 4'd0) begin
            if (rem_q != 3'd0) begin
              timer_q   <= HIGH_LOAD;
              state_q   <= HIGH;
              count_1_q <= ~pl_q;
              count_2_q <= pl_q;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            timer_q <= timer_q - 4'd1;
          end
        end
        default: begin
          state_q   <= IDLE;
          count_1_q <= 1'b0;
          count_2_q <= 1'b0;
        end
      endcase
    end
  end

  assign COUNT_1  = count_1_q;
  assign COUNT_2  = count_2_q;
  assign BUSY     = (cnt_q != '0) | (state_q != IDLE);
  assign FULL     = full;
  assign OVERFLOW = overflow_q;

endmodule

// File: tb/tb_score_pulse_gen.sv
// Bench for score_pulse_gen: vector table, directed multi-cycle sequences and
// randomized traffic checked every cycle against an event-level reference model.
module tb_score_pulse_gen;

  localparam int H  = 4;
  localparam int G  = 4;
  localparam int FD = 4;
  localparam int P  = H + G;

  logic       CLK_DRV = 1'b0;
  logic       RESET = 1'b1;
  logic       START_GAME_N = 1'b1;
  logic       HIT = 1'b0;
  logic [2:0] HIT_POINTS = 3'd0;
  logic       HIT_PLAYER2 = 1'b0;
  logic       COUNT_1, COUNT_2, BUSY, FULL, OVERFLOW;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  score_pulse_gen #(.PULSE_HIGH(H), .PULSE_GAP(G), .FIFO_DEPTH(FD)) dut (
    .CLK_DRV(CLK_DRV), .RESET(RESET), .START_GAME_N(START_GAME_N),
    .HIT(HIT), .HIT_POINTS(HIT_POINTS), .HIT_PLAYER2(HIT_PLAYER2),
    .COUNT_1(COUNT_1), .COUNT_2(COUNT_2), .BUSY(BUSY), .FULL(FULL),
    .OVERFLOW(OVERFLOW)
  );

  always #5 CLK_DRV = ~CLK_DRV;

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, want %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (event level) ----------------
  typedef struct { int pts; bit p2; } ev_t;
  ev_t m_q[$];
  int  kcyc = 0;
  bit  m_act = 1'b0;
  int  m_start = 0, m_end = 0;
  bit  m_pl = 1'b0;
  bit  m_ovf = 1'b0;

  // Event popped at edge k is high from cycle k and lasts pts*P cycles; the
  // FSM is idle in the cycle at m_end and may pop at the following edge.
  always @(posedge CLK_DRV) begin
    bit  full_prev;
    ev_t e;
    kcyc++;
    if (RESET || !START_GAME_N) begin
      m_q.delete();
      m_act = 1'b0;
      m_ovf = 1'b0;
    end else begin
      if (m_act && (kcyc - 1) >= m_end) m_act = 1'b0;
      full_prev = (m_q.size() == FD);
      if (!m_act && m_q.size() != 0) begin
        e       = m_q.pop_front();
        m_act   = 1'b1;
        m_start = kcyc;
        m_end   = kcyc + e.pts * P;
        m_pl    = e.p2;
      end
      if (HIT && HIT_POINTS != 3'd0) begin
        if (full_prev) m_ovf = 1'b1;
        else begin
          e.pts = int'(HIT_POINTS);
          e.p2  = HIT_PLAYER2;
          m_q.push_back(e);
        end
      end
    end
  end

  always @(negedge CLK_DRV) begin
    bit in_train, hi;
    if (chk_en) begin
      in_train = m_act && (kcyc < m_end);
      hi = in_train && (((kcyc - m_start) % P) < H);
      chk("model_count_1", COUNT_1, hi && !m_pl);
      chk("model_count_2", COUNT_2, hi && m_pl);
      chk("model_busy", BUSY, (m_q.size() != 0) || in_train);
      chk("model_full", FULL, m_q.size() == FD);
      chk("model_overflow", OVERFLOW, m_ovf);
      chk("count_exclusive", COUNT_1 & COUNT_2, 1'b0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge CLK_DRV);
  endtask

  task automatic set_in(input logic rst, input logic sgn, input logic hit,
                        input logic [2:0] pts, input logic p2);
    RESET = rst; START_GAME_N = sgn; HIT = hit; HIT_POINTS = pts; HIT_PLAYER2 = p2;
  endtask

  task automatic set_idle();
    set_in(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic reset_dut();
    set_in(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    tick();
    set_idle();
  endtask

  // {rst, sgn, hit, pts, p2} applied for one cycle, then expected
  // {c1, c2, busy, full, ovf} in the cycle after the sampling edge.
  typedef struct packed {
    logic rst, sgn, hit; logic [2:0] pts; logic p2;
    logic c1, c2, busy, full, ovf;
  } vec_t;
  vec_t tab [20];

  initial begin
    int  j, c1p, c2p, last1, first2, w;
    bit  prev1, prev2, full_seen, any_c2;
    int  blk;

    tab[0]  = 12'b1_1_0_000_0_00000;
    tab[1]  = 12'b0_1_1_000_0_00000;   // zero-point hit ignored
    tab[2]  = 12'b0_1_1_001_0_00100;
    tab[3]  = 12'b0_1_0_000_0_10100;
    tab[4]  = 12'b0_1_0_000_0_10100;
    tab[5]  = 12'b0_1_0_000_0_10100;
    tab[6]  = 12'b0_1_0_000_0_10100;
    tab[7]  = 12'b0_1_0_000_0_00100;
    tab[8]  = 12'b0_1_0_000_0_00100;
    tab[9]  = 12'b0_1_0_000_0_00100;
    tab[10] = 12'b0_1_0_000_0_00100;
    tab[11] = 12'b0_1_0_000_0_00000;
    tab[12] = 12'b0_1_1_111_1_00100;
    tab[13] = 12'b0_1_1_111_1_01100;
    tab[14] = 12'b0_1_1_111_1_01100;
    tab[15] = 12'b0_1_1_111_1_01100;
    tab[16] = 12'b0_1_1_111_1_01110;
    tab[17] = 12'b0_1_1_111_1_00111;   // dropped while full
    tab[18] = 12'b0_0_0_000_0_00000;   // START_GAME_N clears all
    tab[19] = 12'b0_1_0_000_0_00000;

    set_in(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    tick();
    chk_en = 1'b1;
    chk("reset_busy", BUSY, 1'b0);
    chk("reset_overflow", OVERFLOW, 1'b0);

    // vector table
    for (int i = 0; i < 20; i++) begin
      set_in(tab[i].rst, tab[i].sgn, tab[i].hit, tab[i].pts, tab[i].p2);
      tick();
      chk($sformatf("tab%0d_count_1", i), COUNT_1, tab[i].c1);
      chk($sformatf("tab%0d_count_2", i), COUNT_2, tab[i].c2);
      chk($sformatf("tab%0d_busy", i), BUSY, tab[i].busy);
      chk($sformatf("tab%0d_full", i), FULL, tab[i].full);
      chk($sformatf("tab%0d_overflow", i), OVERFLOW, tab[i].ovf);
    end

    // single event of 3 points, player 1
    reset_dut();
    set_in(1'b0, 1'b1, 1'b1, 3'd3, 1'b0);
    for (j = 1; j <= 30; j++) begin
      tick();
      if (j == 1) set_idle();
      chk($sformatf("single_c1_t%0d", j), COUNT_1,
          (j >= 2 && j <= 5) || (j >= 10 && j <= 13) || (j >= 18 && j <= 21));
      chk($sformatf("single_c2_t%0d", j), COUNT_2, 1'b0);
      chk($sformatf("single_busy_t%0d", j), BUSY, j < 26);
    end

    // player interleave: (5,P1) then (2,P2)
    reset_dut();
    set_in(1'b0, 1'b1, 1'b1, 3'd5, 1'b0);
    c1p = 0; c2p = 0; last1 = -1; first2 = -1; prev1 = 0; prev2 = 0; j = 0;
    do begin
      tick();
      j++;
      if (j == 1) set_in(1'b0, 1'b1, 1'b1, 3'd2, 1'b1);
      else if (j == 2) set_idle();
      if (COUNT_1 && !prev1) c1p++;
      if (COUNT_2 && !prev2) c2p++;
      if (COUNT_1) last1 = j;
      if (COUNT_2 && first2 < 0) first2 = j;
      prev1 = COUNT_1; prev2 = COUNT_2;
    end while ((j <= 2 || BUSY) && j < 200);
    chk("interleave_timeout", BUSY, 1'b0);
    chk_int("interleave_c1_pulses", c1p, 5);
    chk_int("interleave_c2_pulses", c2p, 2);
    chk_int("interleave_gap", first2 - last1, G + 2);
    chk_int("interleave_end_cycle", j, 59);

    // overflow: six 7-point hits on consecutive cycles
    reset_dut();
    c1p = 0; prev1 = 0; full_seen = 0;
    for (int k = 0; k < 6; k++) begin
      set_in(1'b0, 1'b1, 1'b1, 3'd7, 1'b0);
      tick();
      if (COUNT_1 && !prev1) c1p++;
      prev1 = COUNT_1;
      if (FULL) full_seen = 1'b1;
    end
    set_idle();
    w = 0;
    while (BUSY && w < 600) begin
      tick();
      w++;
      if (COUNT_1 && !prev1) c1p++;
      prev1 = COUNT_1;
      if (FULL) full_seen = 1'b1;
    end
    chk("overflow_timeout", BUSY, 1'b0);
    chk_int("overflow_pulses", c1p, 35);
    chk("overflow_full_seen", full_seen, 1'b1);
    chk("overflow_sticky", OVERFLOW, 1'b1);

    // START_GAME_N clears OVERFLOW; next single-point hit gives one pulse
    set_in(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    tick();
    chk("start_overflow", OVERFLOW, 1'b0);
    chk("start_busy", BUSY, 1'b0);
    chk("start_full", FULL, 1'b0);
    set_in(1'b0, 1'b1, 1'b1, 3'd1, 1'b0);
    c1p = 0; prev1 = 0; j = 0;
    do begin
      tick();
      j++;
      if (j == 1) set_idle();
      if (COUNT_1 && !prev1) c1p++;
      prev1 = COUNT_1;
    end while ((j <= 1 || BUSY) && j < 100);
    chk("start_timeout", BUSY, 1'b0);
    chk_int("start_pulses", c1p, 1);

    // reset during the third high phase of a 7-point P2 train
    reset_dut();
    set_in(1'b0, 1'b1, 1'b1, 3'd7, 1'b1);
    for (j = 1; j <= 20; j++) begin
      tick();
      if (j == 1) set_idle();
      if (j == 19) begin
        chk("midreset_c2_before", COUNT_2, 1'b1);
        RESET = 1'b1;
      end
      if (j == 20) begin
        chk("midreset_c2_after", COUNT_2, 1'b0);
        chk("midreset_busy_after", BUSY, 1'b0);
        RESET = 1'b0;
      end
    end
    any_c2 = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (COUNT_2 || BUSY) any_c2 = 1'b1;
    end
    chk("midreset_no_resume", any_c2, 1'b0);

    // randomized traffic, alternating heavy and light hit rates
    for (int k = 0; k < 4000; k++) begin
      int r;
      blk = (k / 500) % 2;
      r = int'($urandom_range(0, 999));
      set_in(r < 3, !(r >= 3 && r < 6),
             ($urandom_range(0, 99) < (blk != 0 ? 40 : 4)),
             3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      tick();
    end
    set_idle();
    w = 0;
    while (BUSY && w < 1000) begin
      tick();
      w++;
    end
    chk("random_drain_timeout", BUSY, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
